// File: rtl/cpu_decode_scoreboard_pkg.sv
// cpu_decode_scoreboard_pkg
// Shared definitions for the SLURM32 decode/scoreboard stage. This file holds
// the instruction class encodings, the field positions and small pure helpers.
// The helpers extract the fields and classify the operand usage of each class.
// Field positions assume a 32-bit instruction word. Register selects are at
// most FIELD_W bits wide.
package cpu_decode_scoreboard_pkg;

    // Instruction class encodings (ins[31:28])
    localparam logic [3:0] CLASS_ALU_RR = 4'h1;  // reads src1, src2; writes dest
    localparam logic [3:0] CLASS_ALU_RI = 4'h2;  // reads src1; writes dest
    localparam logic [3:0] CLASS_STORE  = 4'h3;  // reads src1, src2; no dest

    // Field least-significant-bit positions
    localparam int CLASS_LSB = 28;
    localparam int DEST_LSB  = 16;
    localparam int SRC1_LSB  = 8;
    localparam int SRC2_LSB  = 0;

    // Width of each raw register field in the instruction word
    localparam int FIELD_W   = 8;

    // Class field. The shift keeps the helper well-defined over the whole word.
    function automatic logic [3:0] get_class(input logic [31:0] ins);
        return 4'(ins >> CLASS_LSB);
    endfunction

    function automatic logic [FIELD_W-1:0] get_dest(input logic [31:0] ins);
        return FIELD_W'(ins >> DEST_LSB);
    endfunction

    function automatic logic [FIELD_W-1:0] get_src1(input logic [31:0] ins);
        return FIELD_W'(ins >> SRC1_LSB);
    endfunction

    function automatic logic [FIELD_W-1:0] get_src2(input logic [31:0] ins);
        return FIELD_W'(ins >> SRC2_LSB);
    endfunction

    // Operand usage per class. Unknown classes use nothing.
    function automatic logic reads_src1(input logic [3:0] cls);
        return (cls == CLASS_ALU_RR) || (cls == CLASS_ALU_RI) || (cls == CLASS_STORE);
    endfunction

    function automatic logic reads_src2(input logic [3:0] cls);
        return (cls == CLASS_ALU_RR) || (cls == CLASS_STORE);
    endfunction

    function automatic logic writes_dest(input logic [3:0] cls);
        return (cls == CLASS_ALU_RR) || (cls == CLASS_ALU_RI);
    endfunction

endpackage

// File: rtl/cpu_decode_scoreboard_fields.sv
// cpu_decode_fields
// Purely combinational decode of the register selects of one instruction.
// A select that its class does not use comes out as 0. Register 0 never
// hazards, so a 0 select is safe to feed straight into the scoreboard lookup.
module cpu_decode_fields
    import cpu_decode_scoreboard_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int REGISTER_BITS = 8
) (
    input  logic [BITS-1:0]          instr_i,
    output logic [REGISTER_BITS-1:0] src1_sel_o,
    output logic [REGISTER_BITS-1:0] src2_sel_o,
    output logic [REGISTER_BITS-1:0] dest_sel_o
);

    logic [3:0]         cls;
    logic [FIELD_W-1:0] dest_f;
    logic [FIELD_W-1:0] src1_f;
    logic [FIELD_W-1:0] src2_f;

    // Raw field extraction from the fixed 32-bit layout
    always_comb begin
        cls    = get_class(instr_i[31:0]);
        dest_f = get_dest(instr_i[31:0]);
        src1_f = get_src1(instr_i[31:0]);
        src2_f = get_src2(instr_i[31:0]);
    end

    // Mask each select by whether its class actually uses that operand
    always_comb begin
        src1_sel_o = '0;
        src2_sel_o = '0;
        dest_sel_o = '0;
        if (reads_src1(cls)) begin
            src1_sel_o = src1_f[REGISTER_BITS-1:0];
        end
        if (reads_src2(cls)) begin
            src2_sel_o = src2_f[REGISTER_BITS-1:0];
        end
        if (writes_dest(cls)) begin
            dest_sel_o = dest_f[REGISTER_BITS-1:0];
        end
    end

endmodule

// File: rtl/cpu_decode_scoreboard.sv
// cpu_decode_scoreboard
// SLURM32 decode stage between fetch and register read. It decodes the
// register selects, blocks RAW/WAW hazards against a per-register
// pending-write scoreboard, and registers the issued instruction into a
// one-entry output slot.
//
// Optional feature macro: SLURM32_DECODE_BYPASS_EN
//   When defined, a writeback in the current cycle is already removed from the
//   pending bits seen by the hazard check. A waiting instruction then issues
//   in the writeback cycle. When undefined, the check sees only the registered
//   pending bits, which costs one extra stall cycle.
//
// Handshakes (both sides use the same rule): a transfer happens on a rising
// edge where valid && ready. Valid must not depend on ready. Ready may depend
// combinationally on valid and on the stage state. Upstream: in_valid /
// in_ready. Downstream: out_valid / out_ready. While out_valid && !out_ready,
// every output register holds its value.
module cpu_decode_scoreboard
    import cpu_decode_scoreboard_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int REGISTER_BITS = 8,
    parameter int CNT_BITS      = 16
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic [BITS-1:0]          in_instruction,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BITS-1:0]          out_instruction,
    output logic [REGISTER_BITS-1:0] regA_sel,
    output logic [REGISTER_BITS-1:0] regB_sel,
    output logic [REGISTER_BITS-1:0] dest_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     wb_valid,
    input  logic [REGISTER_BITS-1:0] wb_reg,
    input  logic                     flush,
    output logic [CNT_BITS-1:0]      hazard_count
);

    localparam int NUM_REGS = 2 ** REGISTER_BITS;

    // Decoded selects of the instruction presented on in_instruction
    logic [REGISTER_BITS-1:0] dec_src1;
    logic [REGISTER_BITS-1:0] dec_src2;
    logic [REGISTER_BITS-1:0] dec_dest;

    // Scoreboard: one pending-write bit per register, bit 0 always 0
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_chk;
    logic [NUM_REGS-1:0] wb_clr_mask;

    // Output slot
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic [BITS-1:0]          out_instr_q;
    logic [BITS-1:0]          out_instr_d;
    logic [REGISTER_BITS-1:0] rega_q;
    logic [REGISTER_BITS-1:0] rega_d;
    logic [REGISTER_BITS-1:0] regb_q;
    logic [REGISTER_BITS-1:0] regb_d;
    logic [REGISTER_BITS-1:0] dest_q;
    logic [REGISTER_BITS-1:0] dest_d;

    // Saturating hazard-stall counter
    logic [CNT_BITS-1:0] hcount_q;
    logic [CNT_BITS-1:0] hcount_d;

    logic hazard;
    logic issue;

    cpu_decode_fields #(
        .BITS          (BITS),
        .REGISTER_BITS (REGISTER_BITS)
    ) u_fields (
        .instr_i    (in_instruction),
        .src1_sel_o (dec_src1),
        .src2_sel_o (dec_src2),
        .dest_sel_o (dec_dest)
    );

    // One-hot mask of the register retiring this cycle (all zero when none)
    always_comb begin
        wb_clr_mask = '0;
        if (wb_valid) begin
            wb_clr_mask[wb_reg] = 1'b1;
        end
    end

`ifdef SLURM32_DECODE_BYPASS_EN
    // Hazard lookup sees the same-cycle writeback as already retired
    always_comb begin
        pending_chk = pending_q & ~wb_clr_mask;
    end
`else
    // Hazard lookup sees only the registered pending bits
    always_comb begin
        pending_chk = pending_q;
    end
`endif

    // Hazard detection, input handshake and issue qualification
    always_comb begin
        hazard   = in_valid && (pending_chk[dec_src1] ||
                                pending_chk[dec_src2] ||
                                pending_chk[dec_dest]);
        in_ready = RSTb && !hazard && (!out_valid_q || out_ready) && !flush;
        issue    = in_valid && in_ready;
    end

    // Scoreboard next state: retire, then set the new writer (set wins), flush clears all
    always_comb begin
        pending_d = pending_q & ~wb_clr_mask;
        if (issue && (dec_dest != '0)) begin
            pending_d[dec_dest] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    // Output slot next state: load on issue, empty on consume or flush, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        rega_d      = rega_q;
        regb_d      = regb_q;
        dest_d      = dest_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instruction;
            rega_d      = dec_src1;
            regb_d      = dec_src2;
            dest_d      = dec_dest;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    // Hazard-stall counter: counts blocked cycles and sticks at all-ones; flush does not clear it
    always_comb begin
        hcount_d = hcount_q;
        if (hazard && (hcount_q != '1)) begin
            hcount_d = hcount_q + CNT_BITS'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            rega_q      <= '0;
            regb_q      <= '0;
            dest_q      <= '0;
            hcount_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            rega_q      <= rega_d;
            regb_q      <= regb_d;
            dest_q      <= dest_d;
            hcount_q    <= hcount_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign regA_sel        = rega_q;
    assign regB_sel        = regb_q;
    assign dest_sel        = dest_q;
    assign hazard_count    = hcount_q;

endmodule

// File: tb/tb_cpu_decode_scoreboard.sv
// tb_cpu_decode_scoreboard
// Directed bench for cpu_decode_scoreboard. Issued instructions are pushed as
// expected output-slot contents and compared when the slot is consumed.
// The bench follows SLURM32_DECODE_BYPASS_EN when that macro is defined.
`timescale 1ns/1ps
module tb_cpu_decode_scoreboard;

    localparam int BITS = 32;
    localparam int RB   = 8;
    localparam int CB   = 4;
    localparam int W    = BITS + 3 * RB;
`ifdef SLURM32_DECODE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          CLK;
    logic          RSTb;
    logic [BITS-1:0] in_instruction;
    logic          in_valid;
    logic          in_ready;
    logic [BITS-1:0] out_instruction;
    logic [RB-1:0] regA_sel;
    logic [RB-1:0] regB_sel;
    logic [RB-1:0] dest_sel;
    logic          out_valid;
    logic          out_ready;
    logic          wb_valid;
    logic [RB-1:0] wb_reg;
    logic          flush;
    logic [CB-1:0] hazard_count;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    cpu_decode_scoreboard #(
        .BITS          (BITS),
        .REGISTER_BITS (RB),
        .CNT_BITS      (CB)
    ) dut (
        .CLK             (CLK),
        .RSTb            (RSTb),
        .in_instruction  (in_instruction),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_instruction (out_instruction),
        .regA_sel        (regA_sel),
        .regB_sel        (regB_sel),
        .dest_sel        (dest_sel),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .wb_valid        (wb_valid),
        .wb_reg          (wb_reg),
        .flush           (flush),
        .hazard_count    (hazard_count)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_hc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {instruction, regA, regB, dest}
    function automatic logic [W-1:0] model(input logic [31:0] ins);
        logic [RB-1:0] a;
        logic [RB-1:0] b;
        logic [RB-1:0] d;
        a = '0;
        b = '0;
        d = '0;
        case (ins[31:28])
            4'h1: begin a = ins[15:8]; b = ins[7:0]; d = ins[23:16]; end
            4'h2: begin a = ins[15:8]; d = ins[23:16]; end
            4'h3: begin a = ins[15:8]; b = ins[7:0]; end
            default: ;
        endcase
        return {ins, a, b, d};
    endfunction

    // Build an instruction with random filler in the unused nibble
    function automatic logic [31:0] mk(input logic [3:0] cls, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        logic [3:0] fill;
        fill = 4'($urandom_range(0, 15));
        return {cls, fill, d, s1, s2};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        in_instruction = ins;
        in_valid       = 1'b1;
        #1;
    endtask

    task automatic push(input logic [31:0] ins);
        exp_q.push_back(model(ins));
    endtask

    task automatic retire(input logic [7:0] r);
        wb_valid = 1'b1;
        wb_reg   = r;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic hz();
        if (exp_hc < (2 ** CB) - 1) exp_hc++;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge CLK) begin
        if (RSTb && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 64'(out_valid), 64'd0);
            end else begin
                check("out_slot", 64'({out_instruction, regA_sel, regB_sel, dest_sel}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [31:0] i0, i1, i2, i3, i4, i5, i6, i7, i8, i9, i10, i11, i12, i13;

    initial begin
        RSTb = 1'b0; in_instruction = '0; in_valid = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
        tick(); tick();

        // Reset state
        drive(mk(4'h1, 8'd3, 8'd1, 8'd2));
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sels", 64'({regA_sel, regB_sel, dest_sel}), 64'd0);
        check("rst_out_ins", 64'(out_instruction), 64'd0);
        check("rst_hc", 64'(hazard_count), 64'd0);
        in_valid = 1'b0;
        tick();
        RSTb = 1'b1;

        // Back-to-back stream
        i0 = mk(4'h1, 8'd3, 8'd1, 8'd2);
        drive(i0); check("s1_ready", 64'(in_ready), 64'd1); push(i0); tick();
        check("s1_out", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 8'd1, 8'd2, 8'd3});
        i1 = mk(4'h1, 8'd4, 8'd5, 8'd6);
        drive(i1); check("s2_ready", 64'(in_ready), 64'd1); push(i1); tick();
        check("s2_out", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 8'd5, 8'd6, 8'd4});
        in_valid = 1'b0; tick();
        check("s2_drain", 64'(out_valid), 64'd0);
        retire(8'd3); retire(8'd4);

        // RAW hazard on r3
        i0 = mk(4'h1, 8'd3, 8'd1, 8'd2);
        drive(i0); push(i0); tick();
        i2 = mk(4'h2, 8'd7, 8'd3, 8'h55);
        drive(i2); check("raw_ready0", 64'(in_ready), 64'd0);
        tick(); hz(); check("raw_hc1", 64'(hazard_count), 64'(exp_hc));
        check("raw_ready1", 64'(in_ready), 64'd0);
        tick(); hz(); check("raw_hc2", 64'(hazard_count), 64'(exp_hc));
        wb_valid = 1'b1; wb_reg = 8'd3; #1;
        check("raw_wb_ready", 64'(in_ready), 64'(BYPASS));
        if (BYPASS) push(i2); else hz();
        tick();
        wb_valid = 1'b0;
        in_valid = !BYPASS; #1;
        check("raw_after_wb_ready", 64'(in_ready), 64'd1);
        check("raw_hc3", 64'(hazard_count), 64'(exp_hc));
        if (!BYPASS) begin push(i2); tick(); end
        in_valid = 1'b0;
        check("raw_issued", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 8'd3, 8'd0, 8'd7});
        tick(); retire(8'd7);

        // WAW plus same-cycle set and clear on r9
        i3 = mk(4'h1, 8'd9, 8'd1, 8'd1);
        drive(i3); check("waw_first_ready", 64'(in_ready), 64'd1); push(i3); tick();
        in_valid = 1'b0; tick();
        drive(i3); check("waw_ready0", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_reg = 8'd9; #1;
        check("waw_wb_ready", 64'(in_ready), 64'(BYPASS));
        if (!BYPASS) begin hz(); tick(); end
        check("waw_issue_ready", 64'(in_ready), 64'd1);
        push(i3); tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        i4 = mk(4'h2, 8'd9, 8'd0, 8'h12);
        drive(i4); check("waw_set_wins", 64'(in_ready), 64'd0);
        tick(); hz(); check("waw_hc", 64'(hazard_count), 64'(exp_hc));
        in_valid = 1'b0;
        retire(8'd9);

        // Backpressure
        out_ready = 1'b0;
        i5 = mk(4'h1, 8'd10, 8'd11, 8'd12);
        drive(i5); check("bp_first_ready", 64'(in_ready), 64'd1); push(i5); tick();
        i6 = mk(4'h1, 8'd13, 8'd14, 8'd15);
        drive(i6); check("bp_ready0", 64'(in_ready), 64'd0);
        tick();
        check("bp_hold1", 64'({out_valid, out_instruction, regA_sel, regB_sel, dest_sel}),
              64'({1'b1, i5, 8'd11, 8'd12, 8'd10}));
        tick();
        check("bp_hold2", 64'({out_valid, out_instruction, regA_sel, regB_sel, dest_sel}),
              64'({1'b1, i5, 8'd11, 8'd12, 8'd10}));
        check("bp_ready_held", 64'(in_ready), 64'd0);
        out_ready = 1'b1; #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        push(i6); tick();
        check("bp_next", 64'({out_valid, out_instruction, regA_sel, regB_sel, dest_sel}),
              64'({1'b1, i6, 8'd14, 8'd15, 8'd13}));
        in_valid = 1'b0; tick();
        retire(8'd10); retire(8'd13);

        // Flush with a stalled instruction and a blocked output slot
        out_ready = 1'b0;
        i7 = mk(4'h1, 8'd3, 8'd1, 8'd2);
        drive(i7); push(i7); tick();
        i8 = mk(4'h2, 8'd7, 8'd3, 8'h0F);
        drive(i8); check("fl_ready0", 64'(in_ready), 64'd0);
        tick(); hz();
        flush = 1'b1; #1;
        check("fl_ready_flush", 64'(in_ready), 64'd0);
        hz(); tick();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        void'(exp_q.pop_front());
        out_ready = 1'b1; #1;
        check("fl_ready_after", 64'(in_ready), 64'd1);
        check("fl_hc", 64'(hazard_count), 64'(exp_hc));
        push(i8); tick();
        check("fl_issue", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 8'd3, 8'd0, 8'd7});
        in_valid = 1'b0; tick();
        retire(8'd7);

        // Other classes and r0
        i9 = mk(4'hF, 8'd5, 8'd6, 8'd7);
        drive(i9); push(i9); tick();
        check("cls_f_sels", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 24'd0});
        i10 = mk(4'h1, 8'd6, 8'd5, 8'd7);
        drive(i10); check("cls_f_nopend", 64'(in_ready), 64'd1); push(i10); tick();
        i11 = mk(4'h1, 8'd0, 8'd0, 8'd0);
        drive(i11); check("r0_ready1", 64'(in_ready), 64'd1); push(i11); tick();
        drive(i11); check("r0_ready2", 64'(in_ready), 64'd1); push(i11); tick();
        i12 = mk(4'h3, 8'd20, 8'd21, 8'd22);
        drive(i12); check("st_ready", 64'(in_ready), 64'd1); push(i12); tick();
        check("st_sels", 64'({regA_sel, regB_sel, dest_sel}), {40'd0, 8'd21, 8'd22, 8'd0});
        drive(mk(4'h1, 8'd20, 8'd1, 8'd2)); check("st_nopend", 64'(in_ready), 64'd1);
        exp_q.push_back(model(in_instruction)); tick();
        in_valid = 1'b0; tick();
        retire(8'd6); retire(8'd20);

        // Reset in mid-stall
        i0 = mk(4'h1, 8'd3, 8'd1, 8'd2);
        drive(i0); push(i0); tick();
        in_valid = 1'b0; tick();
        i13 = mk(4'h2, 8'd7, 8'd3, 8'd1);
        drive(i13); check("rm_ready0", 64'(in_ready), 64'd0);
        tick(); hz(); check("rm_hc", 64'(hazard_count), 64'(exp_hc));
        RSTb = 1'b0; #1;
        check("rm_ready_rst", 64'(in_ready), 64'd0);
        tick(); exp_hc = 0;
        check("rm_hc_rst", 64'(hazard_count), 64'(exp_hc));
        check("rm_out_valid", 64'(out_valid), 64'd0);
        RSTb = 1'b1; #1;
        check("rm_issue_ready", 64'(in_ready), 64'd1);
        push(i13); tick();
        check("rm_issued", 64'({out_valid, regA_sel, regB_sel, dest_sel}), {39'd0, 1'b1, 8'd3, 8'd0, 8'd7});
        in_valid = 1'b0; tick();
        retire(8'd7);

        // Hazard counter saturation, and flush leaves it alone
        i0 = mk(4'h1, 8'd3, 8'd1, 8'd2);
        drive(i0); push(i0); tick();
        in_valid = 1'b0; tick();
        drive(mk(4'h2, 8'd8, 8'd3, 8'd0));
        for (int k = 0; k < 18; k++) begin
            tick(); hz();
        end
        check("hc_sat", 64'(hazard_count), 64'(exp_hc));
        flush = 1'b1; hz(); tick();
        flush = 1'b0; in_valid = 1'b0;
        check("hc_after_flush", 64'(hazard_count), 64'(exp_hc));
        tick();

        check("q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_decode_scoreboard.md
# cpu_decode_scoreboard

Registered, scoreboarded successor to the SLURM32 operand-select decoder. It accepts one instruction per cycle over a valid/ready handshake and decodes source and destination register selects for three instruction classes. It blocks issue on RAW and WAW hazards against a per-register pending-write scoreboard, and presents the decoded operands one cycle later to the register-file read stage. It sits between fetch and register read in the SLURM32 pipeline.

## Interface
- BITS, 32, instruction width; field positions below are fixed for 32.
- REGISTER_BITS, 8, register select width; NUM_REGS = 2**REGISTER_BITS.
- CNT_BITS, 16, hazard-stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTb  in  1  synchronous, active-low reset.
- in_instruction  in  BITS  instruction from fetch.
- in_valid  in  1  in_instruction is valid.
- in_ready  out  1  decoder accepts this cycle.
- out_instruction  out  BITS  registered copy of the issued instruction.
- regA_sel  out  REGISTER_BITS  source 1 select.
- regB_sel  out  REGISTER_BITS  source 2 select.
- dest_sel  out  REGISTER_BITS  destination select (0 = none).
- out_valid  out  1  output slot holds an issued instruction.
- out_ready  in  1  downstream consumes the output slot.
- wb_valid  in  1  a writeback retires this cycle.
- wb_reg  in  REGISTER_BITS  register being written back.
- flush  in  1  kill output slot and all pending writes.
- hazard_count  out  CNT_BITS  saturating count of hazard-stalled cycles.

## Operation
- Fields: class = ins[31:28]; dest = ins[16 +: REGISTER_BITS]; src1 = ins[8 +: REGISTER_BITS]; src2 = ins[0 +: REGISTER_BITS].
- Class 4'h1 (ALU reg-reg): reads src1 and src2, writes dest.
- Class 4'h2 (ALU reg-imm): reads src1, writes dest. regB_sel = 0.
- Class 4'h3 (store): reads src1 and src2. dest_sel = 0.
- Any other class: all selects are 0.
- Unused selects are 0. r0 reads as zero, never hazards, and is never marked pending.
- Scoreboard: NUM_REGS pending bits; bit 0 is tied to 0.
- hazard = in_valid && (pending[src1 used] || pending[src2 used] || pending[dest used]).
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Issue = in_valid && in_ready.
- On issue:
  - the output slot loads the instruction and its selects; out_valid = 1;
  - pending[dest] is set when dest is nonzero.
- When out_valid && out_ready and there is no issue, out_valid drops to 0.
- wb_valid clears pending[wb_reg]. A set and a clear of the same register in one cycle: the set wins, because the new writer is in flight.
- flush:
  - out_valid = 0 next cycle;
  - the whole scoreboard clears;
  - an in_valid in the same cycle is not accepted.
- hazard_count increments each cycle in which in_valid && hazard, and saturates at all-ones. It is not cleared by flush.

## Timing
- Latency is 1 cycle from issue to out_valid and the selects.
- Full throughput is 1 per cycle when hazard-free and out_ready is held high.
- A blocked output (out_valid && !out_ready) deasserts in_ready. All output registers hold their values.
- Reset (RSTb low at an edge) zeroes the following:
  - out_valid, out_instruction, regA_sel, regB_sel, dest_sel;
  - the entire scoreboard;
  - hazard_count.
- in_ready is combinational. It is 0 while RSTb is low.
- Reset in mid-stall drops the pending writes, so the stalled instruction issues on the first cycle after reset.

## Configuration
- SLURM32_DECODE_BYPASS_EN defined:
  - the hazard check uses pending with the same-cycle writeback already cleared;
  - an instruction waiting on wb_reg issues in the writeback cycle.
- SLURM32_DECODE_BYPASS_EN undefined:
  - the hazard check uses the registered pending bits only;
  - the waiting instruction issues the cycle after writeback, one extra stall cycle.

## Structure
- The shared package holds:
  - class encodings (CLASS_ALU_RR = 4'h1, CLASS_ALU_RI = 4'h2, CLASS_STORE = 4'h3);
  - field LSB constants;
  - pure functions for the field extracts and for reads_src1/reads_src2/writes_dest.
- One sub-module, cpu_decode_fields: combinational decode of class and selects, feeding the scoreboard and output register in the top.

## Test plan
- Reset then stream: RR r3←r1,r2; RR r4←r5,r6 with out_ready=1. Required: in_ready stays 1 and out_valid goes high one cycle after the first issue.
  - Cycle 1: regA=1, regB=2, dest=3.
  - Cycle 2: regA=5, regB=6, dest=4.
- RAW hazard: issue RR r3←r1,r2, then RI r7←r3.
  - in_ready stays 0 and hazard_count increments each cycle until wb_valid with wb_reg=3.
  - Issue occurs in the writeback cycle with bypass, or the next cycle without.
- WAW plus same-cycle set and clear:
  - pending r9, then wb_valid r9 in the same cycle that RR r9←r1,r1 issues: pending[9] remains 1;
  - a following RI r9←r0 stalls.
- Backpressure: out_ready=0 with out_valid=1. Required: in_ready=0 and the outputs are held. Raising out_ready accepts the next instruction in the same cycle.
- Flush: pending r3, stalled RI r7←r3, assert flush. Required:
  - out_valid=0 and the scoreboard clears;
  - the RI issues the cycle after flush deasserts.
- r0 and other classes:
  - class 4'hF yields all selects 0 and sets no pending bit;
  - RR r0←r0,r0 never stalls.
